// File: rtl/field_packer.sv
// field_packer: places tagged FIELD_W-bit fields into a NUM_FIELDS-lane word and
// hands it off through a valid/ready output register. Optional out_par port: FIELD_PACKER_PARITY_EN.
module field_packer #(
  parameter int FIELD_W    = 4,
  parameter int NUM_FIELDS = 2,
  parameter int IDX_W      = $clog2(NUM_FIELDS),
  parameter int OUT_W      = FIELD_W*NUM_FIELDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic [FIELD_W-1:0]    in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [NUM_FIELDS-1:0] out_mask,
  output logic                  out_err
`ifdef FIELD_PACKER_PARITY_EN
  ,
  output logic [NUM_FIELDS-1:0] out_par
`endif
);

  localparam logic [IDX_W:0] LP_NUM_LANES = (IDX_W+1)'(NUM_FIELDS);

  logic [OUT_W-1:0]      r_stg_data;
  logic [NUM_FIELDS-1:0] r_stg_mask;
  logic                  r_stg_err;
  logic                  r_stg_done;

  logic                  r_out_valid;
  logic [OUT_W-1:0]      r_out_data;
  logic [NUM_FIELDS-1:0] r_out_mask;
  logic                  r_out_err;

  logic                  w_accept;
  logic                  w_transfer;
  logic                  w_in_range;
  logic [NUM_FIELDS-1:0] w_sel;
  logic [OUT_W-1:0]      w_stg_data_nxt;
  logic [NUM_FIELDS-1:0] w_stg_mask_nxt;
  logic                  w_beat_err;
  logic                  w_complete;

`ifdef FIELD_PACKER_PARITY_EN
  logic [NUM_FIELDS-1:0] r_out_par;

  function automatic logic [NUM_FIELDS-1:0] lane_parity(input logic [OUT_W-1:0] data);
    logic [NUM_FIELDS-1:0] par;
    par = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      par[i] = ^data[i*FIELD_W +: FIELD_W];
    end
    return par;
  endfunction
`endif

  // in_ready depends only on the registered done flag, so there is no combinational input path
  assign in_ready   = !r_stg_done;
  assign w_accept   = in_valid && !r_stg_done;
  assign w_transfer = r_stg_done && (!r_out_valid || out_ready);
  assign w_in_range = ({1'b0, in_idx} < LP_NUM_LANES);

  // Lane decode and post-write staging values for the current beat
  always_comb begin
    w_sel          = '0;
    w_stg_data_nxt = r_stg_data;
    w_stg_mask_nxt = r_stg_mask;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      w_sel[i] = w_accept && w_in_range && (in_idx == IDX_W'(i));
      w_stg_data_nxt[i*FIELD_W +: FIELD_W] = w_sel[i] ? in_data
                                                      : r_stg_data[i*FIELD_W +: FIELD_W];
      w_stg_mask_nxt[i] = r_stg_mask[i] | w_sel[i];
    end
    w_beat_err = (|(w_sel & r_stg_mask)) || (w_accept && !w_in_range);
    w_complete = in_last || (&w_stg_mask_nxt);
  end

  // Staging word: collects beats, cleared when handed to the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_data <= '0;
      r_stg_mask <= '0;
      r_stg_err  <= 1'b0;
      r_stg_done <= 1'b0;
    end else if (w_transfer) begin
      r_stg_data <= '0;
      r_stg_mask <= '0;
      r_stg_err  <= 1'b0;
      r_stg_done <= 1'b0;
    end else if (w_accept) begin
      r_stg_data <= w_stg_data_nxt;
      r_stg_mask <= w_stg_mask_nxt;
      r_stg_err  <= r_stg_err | w_beat_err;
      r_stg_done <= w_complete;
    end else begin
      r_stg_data <= r_stg_data;
      r_stg_mask <= r_stg_mask;
      r_stg_err  <= r_stg_err;
      r_stg_done <= r_stg_done;
    end
  end

  // Output register: holds the word stable until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_transfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_stg_data;
      r_out_mask  <= r_stg_mask;
      r_out_err   <= r_stg_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
      r_out_mask  <= r_out_mask;
      r_out_err   <= r_out_err;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
      r_out_mask  <= r_out_mask;
      r_out_err   <= r_out_err;
    end
  end

`ifdef FIELD_PACKER_PARITY_EN
  // Lane parity captured with the word; unwritten lanes are zero so their parity is zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_par <= '0;
    end else if (w_transfer) begin
      r_out_par <= lane_parity(r_stg_data);
    end else begin
      r_out_par <= r_out_par;
    end
  end

  assign out_par = r_out_par;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_mask  = r_out_mask;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_field_packer.sv
// Directed bench for field_packer (FIELD_W=4, NUM_FIELDS=2): vector table plus
// hand-written backpressure and mid-word reset sequences.
module tb_field_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [0:0] in_idx = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_mask;
  logic       out_err;
`ifdef FIELD_PACKER_PARITY_EN
  logic [1:0] out_par;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  field_packer #(.FIELD_W(4), .NUM_FIELDS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask), .out_err(out_err)
`ifdef FIELD_PACKER_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nb;
    logic [2:0]  idx;
    logic [11:0] data;
    logic [2:0]  last;
    logic [7:0]  exp_data;
    logic [1:0]  exp_mask;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic idx, input logic [3:0] d, input logic last);
    int budget;
    budget = 20;
    in_valid = 1'b1;
    in_idx   = idx;
    in_data  = d;
    in_last  = last;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!in_ready) check("beat_accept_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

`ifdef FIELD_PACKER_PARITY_EN
  function automatic logic [1:0] exp_par(input logic [7:0] w);
    return {^w[7:4], ^w[3:0]};
  endfunction
`endif

  initial begin
    vecs[0] = '{2, 3'b010, 12'h05A, 3'b000, 8'h5A, 2'b11, 1'b0};
    vecs[1] = '{1, 3'b001, 12'h00C, 3'b001, 8'hC0, 2'b10, 1'b0};
    vecs[2] = '{3, 3'b100, 12'h173, 3'b000, 8'h17, 2'b11, 1'b1};
    vecs[3] = '{2, 3'b001, 12'h093, 3'b000, 8'h39, 2'b11, 1'b0};
    vecs[4] = '{1, 3'b000, 12'h006, 3'b001, 8'h06, 2'b01, 1'b0};
    vecs[5] = '{2, 3'b011, 12'h02F, 3'b010, 8'h20, 2'b10, 1'b1};

    #3;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  {24'd0, out_data},  32'd0);
    check("rst_mask",  {30'd0, out_mask},  32'd0);
    check("rst_err",   {31'd0, out_err},   32'd0);
    #4 rst_n = 1'b1;
    tick();
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      out_ready = 1'b1;
      for (int b = 0; b < vecs[v].nb; b++) begin
        send_beat(vecs[v].idx[b], vecs[v].data[b*4 +: 4], vecs[v].last[b]);
      end
      check($sformatf("v%0d_ready_low", v), {31'd0, in_ready}, 32'd0);
      check($sformatf("v%0d_valid_early", v), {31'd0, out_valid}, 32'd0);
      tick();
      check($sformatf("v%0d_valid", v), {31'd0, out_valid}, 32'd1);
      check($sformatf("v%0d_data", v), {24'd0, out_data}, {24'd0, vecs[v].exp_data});
      check($sformatf("v%0d_mask", v), {30'd0, out_mask}, {30'd0, vecs[v].exp_mask});
      check($sformatf("v%0d_err", v),  {31'd0, out_err},  {31'd0, vecs[v].exp_err});
`ifdef FIELD_PACKER_PARITY_EN
      check($sformatf("v%0d_par", v), {30'd0, out_par}, {30'd0, exp_par(vecs[v].exp_data)});
`endif
      check($sformatf("v%0d_ready_back", v), {31'd0, in_ready}, 32'd1);
      tick();
      check($sformatf("v%0d_valid_drop", v), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: first word held while a second completes behind it
    out_ready = 1'b0;
    send_beat(1'b0, 4'h1, 1'b0);
    send_beat(1'b1, 4'h2, 1'b0);
    tick();
    check("bp_first_valid", {31'd0, out_valid}, 32'd1);
    check("bp_first_data",  {24'd0, out_data},  32'h21);
    send_beat(1'b0, 4'h4, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_hold%0d_ready", c), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp_hold%0d_valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_hold%0d_data", c),  {24'd0, out_data},  32'h21);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_second_valid", {31'd0, out_valid}, 32'd1);
    check("bp_second_data",  {24'd0, out_data},  32'h04);
    check("bp_second_mask",  {30'd0, out_mask},  32'd1);
    check("bp_ready_free",   {31'd0, in_ready},  32'd1);
    tick();
    tick();
    check("bp_second_hold", {24'd0, out_data},  32'h04);
    check("bp_second_vhold", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_no_dup", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Mid-word reset with a word sitting in the output register
    send_beat(1'b1, 4'hC, 1'b1);
    tick();
    check("rs_pre_valid", {31'd0, out_valid}, 32'd1);
    send_beat(1'b0, 4'hF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", {31'd0, out_valid}, 32'd0);
    check("rs_data",  {24'd0, out_data},  32'd0);
    check("rs_mask",  {30'd0, out_mask},  32'd0);
    check("rs_err",   {31'd0, out_err},   32'd0);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send_beat(1'b1, 4'h2, 1'b1);
    tick();
    check("rs_after_valid", {31'd0, out_valid}, 32'd1);
    check("rs_after_data",  {24'd0, out_data},  32'h20);
    check("rs_after_mask",  {30'd0, out_mask},  32'd2);
    check("rs_after_err",   {31'd0, out_err},   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
